bus_dev_fifo: RTL and testbench
===============================

BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 The module SHALL have parameter PCKG_SZ, default 64, meaning packet width in bits, with a minimum of 16.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning TX FIFO entries, with a minimum of 2 and any integer allowed.
REQ-003 The module SHALL have parameter ID, default 0, meaning the 8-bit device identifier used by the RX filter.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous active-high reset.
- wr_en  input  1  host write strobe into TX FIFO.
- wr_data  input  PCKG_SZ  host packet to enqueue.
- full  output  1  TX FIFO holds DEPTH entries.
- tx_count  output  $clog2(DEPTH+1)  current TX occupancy.
- pndng  output  1  bus-side pending flag, high when TX FIFO is non-empty.
- D_pop  output  PCKG_SZ  head-of-FIFO packet presented to the bus.
- pop  input  1  bus arbiter consumes the head entry.
- push  input  1  bus delivers a packet to this device.
- D_push  input  PCKG_SZ  delivered packet.
- rx_valid  output  1  rx_data holds an unconsumed packet.
- rx_data  output  PCKG_SZ  last accepted received packet.
- rx_ack  input  1  host consumes rx_data.
- clr_flags  input  1  clears sticky error flags.
- ovf  output  1  sticky: write attempted while full.
- unf  output  1  sticky: pop while empty.
- rx_ovf  output  1  sticky: received packet dropped because the holding register was occupied.

Function
REQ-005 The TX FIFO SHALL be first-word-fall-through: D_pop SHALL combinationally equal the head entry, and pndng SHALL equal (tx_count != 0).
REQ-006 When D_pop is empty, it SHALL drive all zeros.
REQ-007 A write SHALL store wr_data at the tail and increment tx_count; the entry SHALL be visible on D_pop/pndng on the cycle after the write edge if the FIFO was empty (1-cycle latency).
REQ-008 A pop SHALL advance the head and decrement tx_count.
REQ-009 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-010 A wr_en asserted while full and without pop SHALL be discarded, SHALL set ovf, and SHALL leave FIFO contents unchanged.
REQ-011 wr_en and pop asserted together while full SHALL both take effect, with tx_count unchanged.
REQ-012 A pop asserted while empty SHALL be ignored and SHALL set unf; wr_en in the same cycle SHALL still enqueue, giving tx_count=1.
REQ-013 wr_en and pop asserted together with 0<tx_count<DEPTH SHALL both take effect, with tx_count unchanged.
REQ-014 On push, the RX path SHALL capture D_push into rx_data and set rx_valid on the next edge.
REQ-015 rx_ack while rx_valid and without push SHALL clear rx_valid.
REQ-016 push while rx_valid=1 and rx_ack=0 SHALL drop the incoming packet, SHALL retain rx_data, and SHALL set rx_ovf.
REQ-017 push together with rx_ack SHALL capture the new packet, with rx_valid remaining 1.
REQ-018 clr_flags SHALL clear ovf, unf and rx_ovf on the next edge; a same-cycle error event SHALL take priority and leave its flag set.

Reset
REQ-019 Asserting reset SHALL immediately, independent of clk, set pointers, tx_count, full, pndng, rx_valid, ovf, unf and rx_ovf to 0, and set rx_data to 0.
REQ-020 FIFO storage SHALL NOT require reset, but D_pop SHALL read 0 while empty.
REQ-021 Reset asserted mid-transfer SHALL discard all queued and held packets; the first edge after deassertion SHALL behave as from empty.

Configuration
REQ-022 With macro BUS_DEV_FIFO_RX_FILTER_EN defined, a push whose D_push[PCKG_SZ-1 -: 8] != ID SHALL be ignored entirely, with no capture and no rx_ovf.
REQ-023 Without BUS_DEV_FIFO_RX_FILTER_EN, every push SHALL be handled per REQ-014..REQ-017.

Verification
REQ-024 The bench SHALL cover a reset-then-write: reset, then write 0xA5 -> next cycle pndng=1, D_pop=0xA5, tx_count=1.
REQ-025 The bench SHALL cover overfill with DEPTH=16: fill 16 entries 0..15, write a 17th -> full=1, ovf=1, pops return 0..15 in order, and pndng=0 after the 16th pop.
REQ-026 The bench SHALL cover pointer wrap: perform 40 interleaved write/pop pairs at tx_count=15 -> tx_count stays 15 and data order is preserved across the pointer wrap.
REQ-027 The bench SHALL cover pop-when-empty: pop on empty with simultaneous write of 0x3C -> unf=1, tx_count=1, D_pop=0x3C; then clr_flags -> unf=0.
REQ-028 The bench SHALL cover RX overflow: push 0x11, then push 0x22 without rx_ack -> rx_data=0x11, rx_ovf=1; then push 0x33 with rx_ack -> rx_data=0x33, rx_valid=1.
REQ-029 The bench SHALL cover the RX filter: with BUS_DEV_FIFO_RX_FILTER_EN and ID=3, push with top byte 0x05 -> rx_valid stays 0; push with top byte 0x03 -> captured.

Source files
------------

// File: rtl/bus_dev_fifo.sv
// Bus device endpoint: first-word-fall-through TX FIFO toward the bus and a single-entry RX holding register.
// Define BUS_DEV_FIFO_RX_FILTER_EN to drop pushes whose top byte does not match ID.
module bus_dev_fifo #(
    parameter int PCKG_SZ = 64,
    parameter int DEPTH   = 16,
    parameter int ID      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [PCKG_SZ-1:0]         wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] tx_count,
    output logic                       pndng,
    output logic [PCKG_SZ-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         D_push,
    output logic                       rx_valid,
    output logic [PCKG_SZ-1:0]         rx_data,
    input  logic                       rx_ack,
    input  logic                       clr_flags,
    output logic                       ovf,
    output logic                       unf,
    output logic                       rx_ovf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
`ifdef BUS_DEV_FIFO_RX_FILTER_EN
    localparam logic FILTER_ON = 1'b1;
`else
    localparam logic FILTER_ON = 1'b0;
`endif

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [PCKG_SZ-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_r, pndng_r;
    logic               ovf_r, unf_r, rx_ovf_r;
    logic               rx_valid_r;
    logic [PCKG_SZ-1:0] rx_data_r;

    logic               empty_s, full_s, do_pop_s, do_wr_s;
    logic               ovf_set_s, unf_set_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic               id_match_s, rx_hit_s, rx_take_s, rx_drop_s;
    logic               rx_valid_nxt_s;

    // TX control: a pop while full frees the slot the same-cycle write uses.
    always_comb begin
        empty_s      = (count_r == '0);
        full_s       = (count_r == DEPTH_CNT);
        do_pop_s     = pop && !empty_s;
        do_wr_s      = wr_en && (!full_s || do_pop_s);
        ovf_set_s    = wr_en && full_s && !pop;
        unf_set_s    = pop && empty_s;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (do_pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (do_wr_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        case ({do_wr_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // RX acceptance: filtered pushes are invisible to the holding register.
    always_comb begin
        id_match_s     = (D_push[PCKG_SZ-1 -: 8] == 8'(ID));
        rx_hit_s       = push && (id_match_s || !FILTER_ON);
        rx_take_s      = rx_hit_s && (!rx_valid_r || rx_ack);
        rx_drop_s      = rx_hit_s && rx_valid_r && !rx_ack;
        rx_valid_nxt_s = rx_valid_r;
        if (rx_take_s) begin
            rx_valid_nxt_s = 1'b1;
        end else if (rx_ack) begin
            rx_valid_nxt_s = 1'b0;
        end else begin
            rx_valid_nxt_s = rx_valid_r;
        end
    end

    // TX pointer, occupancy and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            pndng_r  <= 1'b0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_CNT);
            pndng_r  <= (count_nxt_s != '0);
        end
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // RX holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
        end else begin
            rx_valid_r <= rx_valid_nxt_s;
            if (rx_take_s) begin
                rx_data_r <= D_push;
            end
        end
    end

    // Sticky error flags; a same-cycle error beats clr_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            ovf_r    <= ovf_set_s || (ovf_r && !clr_flags);
            unf_r    <= unf_set_s || (unf_r && !clr_flags);
            rx_ovf_r <= rx_drop_s || (rx_ovf_r && !clr_flags);
        end
    end

    // Head entry presented combinationally, zero while empty.
    always_comb begin
        if (pndng_r) begin
            D_pop = mem_r[rd_ptr_r];
        end else begin
            D_pop = '0;
        end
    end

    assign full     = full_r;
    assign tx_count = count_r;
    assign pndng    = pndng_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign ovf      = ovf_r;
    assign unf      = unf_r;
    assign rx_ovf   = rx_ovf_r;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_bus_dev_fifo;

    localparam int PCKG_SZ = 64;
    localparam int DEPTH   = 16;
    localparam int ID      = 3;
    localparam int CNT_W   = $clog2(DEPTH + 1);
`ifdef BUS_DEV_FIFO_RX_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               wr_en = 1'b0, pop = 1'b0, push = 1'b0, rx_ack = 1'b0, clr_flags = 1'b0;
    logic [PCKG_SZ-1:0] wr_data = '0, D_push = '0;
    logic               full, pndng, rx_valid, ovf, unf, rx_ovf;
    logic [CNT_W-1:0]   tx_count;
    logic [PCKG_SZ-1:0] D_pop, rx_data;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [PCKG_SZ-1:0] q[$];
    bit                 m_ovf, m_unf, m_rx_ovf, m_rx_valid;
    logic [PCKG_SZ-1:0] m_rx_data;

    bus_dev_fifo #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH), .ID(ID)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
        .clr_flags(clr_flags), .ovf(ovf), .unf(unf), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rx_ovf = 1'b0; m_rx_valid = 1'b0; m_rx_data = '0;
    endfunction

    function automatic void model_step();
        bit e_ovf, e_unf, e_rx, hit;
        e_ovf = 1'b0; e_unf = 1'b0; e_rx = 1'b0;
        if (pop) begin
            if (q.size() == 0) e_unf = 1'b1;
            else void'(q.pop_front());
        end
        if (wr_en) begin
            if (q.size() < DEPTH) q.push_back(wr_data);
            else e_ovf = 1'b1;
        end
        hit = push && (!FILT || D_push[PCKG_SZ-1 -: 8] == 8'(ID));
        if (hit && (!m_rx_valid || rx_ack)) begin
            m_rx_data = D_push; m_rx_valid = 1'b1;
        end else if (hit) begin
            e_rx = 1'b1;
        end else if (rx_ack) begin
            m_rx_valid = 1'b0;
        end
        m_ovf    = e_ovf | (m_ovf & !clr_flags);
        m_unf    = e_unf | (m_unf & !clr_flags);
        m_rx_ovf = e_rx  | (m_rx_ovf & !clr_flags);
    endfunction

    task automatic idle();
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rx_ack = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; model_reset();
        pop = 1'b1; wr_en = 1'b1; wr_data = 64'h1234; push = 1'b1; D_push = {8'(ID), 56'h77}; tick();
        wr_en = 1'b1; wr_data = 64'h5678; push = 1'b1; tick();
        @(negedge clk); #2; reset = 1'b1; model_reset(); #1;
        n_cmp++; if (tx_count !== '0) begin n_bad++; $display("FAIL rst_count got %0d want 0", tx_count); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", full); end
        n_cmp++; if (pndng !== 1'b0) begin n_bad++; $display("FAIL rst_pndng got %b want 0", pndng); end
        n_cmp++; if (D_pop !== '0) begin n_bad++; $display("FAIL rst_dpop got %h want 0", D_pop); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rxvalid got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== '0) begin n_bad++; $display("FAIL rst_rxdata got %h want 0", rx_data); end
        n_cmp++; if ({ovf, unf, rx_ovf} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {ovf, unf, rx_ovf}); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset_write();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 64'hA5; tick();
        n_cmp++; if (pndng !== 1'b1) begin n_bad++; $display("FAIL rw_pndng got %b want 1", pndng); end
        n_cmp++; if (D_pop !== 64'hA5) begin n_bad++; $display("FAIL rw_dpop got %h want a5", D_pop); end
        n_cmp++; if (tx_count !== CNT_W'(1)) begin n_bad++; $display("FAIL rw_count got %0d want 1", tx_count); end
        pop = 1'b1; tick();
    endtask

    task automatic test_overfill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 64'(i); tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL of_full got %b want 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL of_ovf_early got %b want 0", ovf); end
        wr_en = 1'b1; wr_data = 64'h99; tick();
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL of_ovf got %b want 1", ovf); end
        n_cmp++; if (tx_count !== CNT_W'(DEPTH)) begin n_bad++; $display("FAIL of_count got %0d want %0d", tx_count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (D_pop !== 64'(i)) begin n_bad++; $display("FAIL of_order got %h want %h", D_pop, 64'(i)); end
            pop = 1'b1; tick();
        end
        n_cmp++; if (pndng !== 1'b0) begin n_bad++; $display("FAIL of_pndng got %b want 0", pndng); end
        n_cmp++; if (D_pop !== '0) begin n_bad++; $display("FAIL of_dpop_empty got %h want 0", D_pop); end
        clr_flags = 1'b1; tick();
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL of_clr got %b want 0", ovf); end
    endtask

    task automatic test_full_wr_pop();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = {$urandom, $urandom}; tick();
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; pop = 1'b1; wr_data = {$urandom, $urandom}; tick();
            n_cmp++; if (tx_count !== CNT_W'(DEPTH)) begin n_bad++; $display("FAIL fwp_count got %0d want %0d", tx_count, DEPTH); end
            n_cmp++; if (D_pop !== q[0]) begin n_bad++; $display("FAIL fwp_head got %h want %h", D_pop, q[0]); end
        end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fwp_ovf got %b want 0", ovf); end
        while (q.size() != 0) begin
            n_cmp++; if (D_pop !== q[0]) begin n_bad++; $display("FAIL fwp_drain got %h want %h", D_pop, q[0]); end
            pop = 1'b1; tick();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH - 1; i++) begin
            wr_en = 1'b1; wr_data = {$urandom, $urandom}; tick();
        end
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; pop = 1'b1; wr_data = {$urandom, $urandom}; tick();
            n_cmp++; if (tx_count !== CNT_W'(DEPTH - 1)) begin n_bad++; $display("FAIL wrap_count got %0d want %0d", tx_count, DEPTH - 1); end
            n_cmp++; if (D_pop !== q[0]) begin n_bad++; $display("FAIL wrap_head got %h want %h", D_pop, q[0]); end
        end
        while (q.size() != 0) begin
            n_cmp++; if (D_pop !== q[0]) begin n_bad++; $display("FAIL wrap_drain got %h want %h", D_pop, q[0]); end
            pop = 1'b1; tick();
        end
    endtask

    task automatic test_pop_empty();
        pop = 1'b1; wr_en = 1'b1; wr_data = 64'h3C; tick();
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL pe_unf got %b want 1", unf); end
        n_cmp++; if (tx_count !== CNT_W'(1)) begin n_bad++; $display("FAIL pe_count got %0d want 1", tx_count); end
        n_cmp++; if (D_pop !== 64'h3C) begin n_bad++; $display("FAIL pe_dpop got %h want 3c", D_pop); end
        clr_flags = 1'b1; tick();
        n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL pe_clr got %b want 0", unf); end
        pop = 1'b1; tick();
        pop = 1'b1; clr_flags = 1'b1; tick();
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL pe_prio got %b want 1", unf); end
        clr_flags = 1'b1; tick();
    endtask

    task automatic test_rx_ovf();
        logic [PCKG_SZ-1:0] p1, p2, p3;
        p1 = {8'(ID), 56'h11}; p2 = {8'(ID), 56'h22}; p3 = {8'(ID), 56'h33};
        rx_ack = 1'b1; tick();
        push = 1'b1; D_push = p1; tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_first_valid got %b want 1", rx_valid); end
        push = 1'b1; D_push = p2; tick();
        n_cmp++; if (rx_data !== p1) begin n_bad++; $display("FAIL rx_keep got %h want %h", rx_data, p1); end
        n_cmp++; if (rx_ovf !== 1'b1) begin n_bad++; $display("FAIL rx_ovf got %b want 1", rx_ovf); end
        push = 1'b1; rx_ack = 1'b1; D_push = p3; tick();
        n_cmp++; if (rx_data !== p3) begin n_bad++; $display("FAIL rx_ackpush got %h want %h", rx_data, p3); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_ackpush_valid got %b want 1", rx_valid); end
        rx_ack = 1'b1; tick();
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_ack got %b want 0", rx_valid); end
        clr_flags = 1'b1; tick();
        n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL rx_clr got %b want 0", rx_ovf); end
    endtask

    task automatic test_filter();
        logic [PCKG_SZ-1:0] pa, pb;
        bit exp_v;
        pa = {8'h05, 56'h55}; pb = {8'h03, 56'h66};
        exp_v = !FILT;
        push = 1'b1; D_push = pa; tick();
        n_cmp++; if (rx_valid !== exp_v) begin n_bad++; $display("FAIL flt_other got %b want %b", rx_valid, exp_v); end
        n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL flt_noovf got %b want 0", rx_ovf); end
        rx_ack = 1'b1; tick();
        push = 1'b1; D_push = pb; tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL flt_match_valid got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== pb) begin n_bad++; $display("FAIL flt_match_data got %h want %h", rx_data, pb); end
        rx_ack = 1'b1; tick();
    endtask

    task automatic test_random();
        logic [PCKG_SZ-1:0] exp_dpop;
        for (int c = 0; c < 1500; c++) begin
            wr_en     = ($urandom_range(0, 99) < 55);
            pop       = ($urandom_range(0, 99) < 45);
            push      = ($urandom_range(0, 99) < 30);
            rx_ack    = ($urandom_range(0, 99) < 40);
            clr_flags = ($urandom_range(0, 99) < 5);
            wr_data   = {$urandom, $urandom};
            D_push    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) D_push[PCKG_SZ-1 -: 8] = 8'(ID);
            tick();
            exp_dpop = (q.size() != 0) ? q[0] : '0;
            n_cmp++; if (tx_count !== CNT_W'(q.size())) begin n_bad++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, tx_count, q.size()); end
            n_cmp++; if (full !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_full c=%0d got %b", c, full); end
            n_cmp++; if (pndng !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_pndng c=%0d got %b", c, pndng); end
            n_cmp++; if (D_pop !== exp_dpop) begin n_bad++; $display("FAIL rnd_dpop c=%0d got %h want %h", c, D_pop, exp_dpop); end
            n_cmp++; if (rx_valid !== m_rx_valid) begin n_bad++; $display("FAIL rnd_rxvalid c=%0d got %b want %b", c, rx_valid, m_rx_valid); end
            n_cmp++; if (rx_data !== m_rx_data) begin n_bad++; $display("FAIL rnd_rxdata c=%0d got %h want %h", c, rx_data, m_rx_data); end
            n_cmp++; if ({ovf, unf, rx_ovf} !== {m_ovf, m_unf, m_rx_ovf}) begin n_bad++; $display("FAIL rnd_flags c=%0d got %b want %b", c, {ovf, unf, rx_ovf}, {m_ovf, m_unf, m_rx_ovf}); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_write();
        test_overfill();
        test_full_wr_pop();
        test_wrap();
        test_pop_empty();
        test_rx_ovf();
        test_filter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
